// File: rtl/instruction_sequencer_pkg.sv
// Shared sizing defaults and helpers for the instruction sequencer.
// Imported by the flag bank and the top level.
package instruction_sequencer_pkg;

  localparam int ADDR_W_DEF  = 8;
  localparam int NUM_ATC_DEF = 8;

  // Index width for a flag bank of n entries, never below one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/instruction_sequencer_atc_flag_bank.sv
// ATC flag bank: go edge capture, set/clear priority, indexed test.
// Set beats clear so an event arriving with its own ATC is kept.
module instruction_sequencer_atc_flag_bank
  import instruction_sequencer_pkg::*;
#(
  parameter int NUM_ATC   = NUM_ATC_DEF,
  parameter int ATC_IDX_W = idx_w(NUM_ATC)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 stall,
  input  logic                 is_atc,
  input  logic [ATC_IDX_W-1:0] atc_index,
  input  logic [NUM_ATC-1:0]   go,
  output logic [NUM_ATC-1:0]   flags,
  output logic                 flag_hit
);

  logic [NUM_ATC-1:0] go_prev;
  logic [NUM_ATC-1:0] rise;
  logic [NUM_ATC-1:0] sel;
  logic [NUM_ATC-1:0] clr;
  logic [NUM_ATC-1:0] flags_nxt;

  assign rise = go & ~go_prev;

  // Decode the tested index; out-of-range indices select nothing.
  always_comb begin
    sel      = '0;
    flag_hit = 1'b0;
    for (int i = 0; i < NUM_ATC; i++) begin
      if (atc_index == ATC_IDX_W'(i)) begin
        sel[i]   = 1'b1;
        flag_hit = flags[i];
      end
    end
  end

  // Per-bit next value: rising go sets, a live ATC clears.
  always_comb begin
    clr       = {NUM_ATC{~stall & is_atc}} & sel & flags;
    flags_nxt = rise | (flags & ~clr);
  end

  // History runs every cycle so a go pulse during stall is kept.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      go_prev <= '0;
      flags   <= '0;
    end else begin
      go_prev <= go;
      flags   <= flags_nxt;
    end
  end

endmodule

// File: rtl/instruction_sequencer.sv
// Instruction sequencer: IP register, taken mux and incrementer.
// ATC flag state lives in the flag bank sub-module.
module instruction_sequencer
  import instruction_sequencer_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int NUM_ATC   = NUM_ATC_DEF,
  parameter int ATC_IDX_W = idx_w(NUM_ATC)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 stall,
  input  logic                 branch_select,
  input  logic                 is_atc,
  input  logic                 alu_cond,
  input  logic [ATC_IDX_W-1:0] atc_index,
  input  logic [ADDR_W-1:0]    jump_target,
  input  logic [NUM_ATC-1:0]   go,
  output logic [ADDR_W-1:0]    ip,
  output logic                 jump_taken,
  output logic [NUM_ATC-1:0]   atc_flags
);

  logic              flag_hit;
  logic              take;
  logic [ADDR_W-1:0] ip_nxt;

  instruction_sequencer_atc_flag_bank #(
    .NUM_ATC   (NUM_ATC),
    .ATC_IDX_W (ATC_IDX_W)
  ) u_flags (
    .clock     (clock),
    .reset     (reset),
    .stall     (stall),
    .is_atc    (is_atc),
    .atc_index (atc_index),
    .go        (go),
    .flags     (atc_flags),
    .flag_hit  (flag_hit)
  );

  // ATC overrides JMP; a stalled cycle never redirects.
  always_comb begin
    take       = is_atc ? flag_hit : (branch_select & alu_cond);
    jump_taken = take & ~stall;
  end

  // Next IP: hold, load target, or step with natural wrap.
  always_comb begin
    ip_nxt = ip;
    if (!stall) begin
      if (take) ip_nxt = jump_target;
      else      ip_nxt = ip + ADDR_W'(1);
    end
  end

  // IP register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) ip <= '0;
    else       ip <= ip_nxt;
  end

endmodule

// File: tb/tb_instruction_sequencer.sv
// Directed self-checking bench for instruction_sequencer.
// Second instance with 5 flags covers out-of-range ATC indices.
module tb_instruction_sequencer;

  logic       clock = 1'b0;
  logic       reset;
  logic       stall;
  logic       branch_select;
  logic       is_atc;
  logic       alu_cond;
  logic [2:0] atc_index;
  logic [7:0] jump_target;
  logic [7:0] go;
  logic [7:0] ip;
  logic       jump_taken;
  logic [7:0] atc_flags;

  logic [2:0] idx2;
  logic [4:0] go2;
  logic [7:0] ip2;
  logic       jump_taken2;
  logic [4:0] atc_flags2;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  instruction_sequencer dut (
    .clock         (clock),
    .reset         (reset),
    .stall         (stall),
    .branch_select (branch_select),
    .is_atc        (is_atc),
    .alu_cond      (alu_cond),
    .atc_index     (atc_index),
    .jump_target   (jump_target),
    .go            (go),
    .ip            (ip),
    .jump_taken    (jump_taken),
    .atc_flags     (atc_flags)
  );

  instruction_sequencer #(.NUM_ATC(5)) dut2 (
    .clock         (clock),
    .reset         (reset),
    .stall         (stall),
    .branch_select (branch_select),
    .is_atc        (is_atc),
    .alu_cond      (alu_cond),
    .atc_index     (idx2),
    .jump_target   (jump_target),
    .go            (go2),
    .ip            (ip2),
    .jump_taken    (jump_taken2),
    .atc_flags     (atc_flags2)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    branch_select = 1'b0;
    is_atc        = 1'b0;
    alu_cond      = 1'b0;
    atc_index     = 3'd0;
    jump_target   = 8'h00;
  endtask

  initial begin
    reset = 1'b1;
    stall = 1'b0;
    go    = 8'h00;
    go2   = 5'h00;
    idx2  = 3'd0;
    idle();
    repeat (2) tick();

    // Reset: dirty some state, then reset asynchronously mid-cycle
    reset = 1'b0;
    go = 8'h01;
    tick();
    tick();
    go = 8'h00;
    chk("pre_rst_ip", ip, 8'h02);
    chk("pre_rst_flags", atc_flags, 8'h01);
    #2;
    reset = 1'b1;
    #1;
    chk("rst_ip", ip, 8'h00);
    chk("rst_flags", atc_flags, 8'h00);
    tick();
    reset = 1'b0;
    tick();
    chk("run_ip1", ip, 8'h01);
    tick();
    chk("run_ip2", ip, 8'h02);
    tick();
    chk("run_ip3", ip, 8'h03);

    // Wrap: jump near the top, then step across FF
    branch_select = 1'b1;
    alu_cond      = 1'b1;
    jump_target   = 8'hFE;
    #1;
    chk("jmp_fe_taken", jump_taken, 1'b1);
    tick();
    chk("jmp_fe_ip", ip, 8'hFE);
    idle();
    tick();
    chk("ip_ff", ip, 8'hFF);
    tick();
    chk("wrap_ip", ip, 8'h00);

    // JMP taken and not taken
    branch_select = 1'b1;
    alu_cond      = 1'b1;
    jump_target   = 8'h40;
    #1;
    chk("jmp_taken", jump_taken, 1'b1);
    tick();
    chk("jmp_ip", ip, 8'h40);
    alu_cond    = 1'b0;
    jump_target = 8'h77;
    #1;
    chk("jmp_nt", jump_taken, 1'b0);
    tick();
    chk("jmp_nt_ip", ip, 8'h41);
    idle();

    // ATC set, take-and-clear, retest
    go = 8'h08;
    tick();
    chk("atc_set", atc_flags, 8'h08);
    is_atc        = 1'b1;
    branch_select = 1'b1;
    atc_index     = 3'd3;
    jump_target   = 8'h20;
    #1;
    chk("atc_taken", jump_taken, 1'b1);
    tick();
    chk("atc_ip", ip, 8'h20);
    chk("atc_clr", atc_flags, 8'h00);
    #1;
    chk("atc_again_nt", jump_taken, 1'b0);
    tick();
    chk("atc_again_ip", ip, 8'h21);
    idle();

    // Stall holds IP but still captures go edges
    stall         = 1'b1;
    branch_select = 1'b1;
    alu_cond      = 1'b1;
    jump_target   = 8'h10;
    go            = 8'h28;
    #1;
    chk("stall_nt", jump_taken, 1'b0);
    tick();
    chk("stall_ip", ip, 8'h21);
    chk("stall_go5", atc_flags, 8'h20);
    tick();
    chk("stall_ip_hold", ip, 8'h21);
    stall = 1'b0;
    #1;
    chk("unstall_taken", jump_taken, 1'b1);
    tick();
    chk("unstall_ip", ip, 8'h10);
    idle();

    // Collision: set and clear same bit, set wins, ATC taken
    go = 8'h2C;
    tick();
    chk("col_pre", atc_flags, 8'h24);
    go = 8'h28;
    tick();
    is_atc        = 1'b1;
    branch_select = 1'b1;
    atc_index     = 3'd2;
    jump_target   = 8'h55;
    go            = 8'h2C;
    #1;
    chk("col_taken", jump_taken, 1'b1);
    tick();
    chk("col_ip", ip, 8'h55);
    chk("col_flags", atc_flags, 8'h24);
    jump_target = 8'h66;
    #1;
    chk("col2_taken", jump_taken, 1'b1);
    tick();
    chk("col2_ip", ip, 8'h66);
    chk("col2_flags", atc_flags, 8'h20);
    idle();

    // Out-of-range index on the 5-flag instance
    go2 = 5'h1F;
    tick();
    chk("oor_set", atc_flags2, 5'h1F);
    is_atc        = 1'b1;
    branch_select = 1'b1;
    jump_target   = 8'h99;
    idx2          = 3'd6;
    #1;
    chk("oor_nt", jump_taken2, 1'b0);
    tick();
    chk("oor_flags", atc_flags2, 5'h1F);
    idx2 = 3'd4;
    #1;
    chk("in_range_taken", jump_taken2, 1'b1);
    tick();
    chk("in_range_ip", ip2, 8'h99);
    chk("in_range_flags", atc_flags2, 5'h0F);
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
